sdram_port_arbiter: RTL and testbench
=====================================

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, data word width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, loader write-buffer entries (power of 2, >=2).
REQ-004 SHALL have parameter RD_TIMEOUT, default 64, max cycles from sd_rd to sd_q_valid.
REQ-005 SHALL have port: clk_sys_131_072, input, 1, the single clock.
REQ-006 SHALL have port: reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port: download_active, input, 1, ROM download in progress; core reads blocked.
REQ-008 SHALL have port: load_wr, input, 1, one-cycle loader write strobe.
REQ-009 SHALL have port: load_addr, input, ADDR_W, loader word address.
REQ-010 SHALL have port: load_data, input, DATA_W, loader write data.
REQ-011 SHALL have port: load_idle, output, 1, FIFO empty and no write in flight.
REQ-012 SHALL have port: load_overflow, output, 1, sticky: a strobe was dropped.
REQ-013 SHALL have port: rd_req, input, 1, core read request (level).
REQ-014 SHALL have port: rd_addr, input, ADDR_W, core read address; held until rd_ack.
REQ-015 SHALL have port: rd_ack, output, 1, one-cycle pulse: read accepted.
REQ-016 SHALL have port: rd_data, output, DATA_W, read result.
REQ-017 SHALL have port: rd_valid, output, 1, one-cycle pulse: rd_data valid.
REQ-018 SHALL have port: rd_error, output, 1, one-cycle pulse: read timed out.
REQ-019 SHALL have port: sd_addr / sd_din, output, ADDR_W / DATA_W, command address and write data to the SDRAM controller.
REQ-020 SHALL have port: sd_wr / sd_rd, output, 1 each, one-cycle command pulses.
REQ-021 SHALL have port: sd_busy, input, 1, controller busy; asserted the cycle after a command, until done.
REQ-022 SHALL have port: sd_q / sd_q_valid, input, DATA_W / 1, read return data and strobe.

Function
REQ-023 SHALL push {load_addr,load_data} into the FIFO on load_wr when not full; a push when full with a pop in the same cycle SHALL be accepted.
REQ-024 SHALL drop load_wr when full without a same-cycle pop and set load_overflow until reset.
REQ-025 SHALL implement states IDLE, WRITE, WR_WAIT, READ, RD_WAIT; all outputs registered.
REQ-026 SHALL, in IDLE with sd_busy=0, grant: a non-empty FIFO -> WRITE (popping the head); rd_req with download_active=0 -> READ; none -> stay IDLE.
REQ-027 SHALL, when both are pending and download_active=0, alternate grants using a last_grant flag (write first after reset).
REQ-028 SHALL never grant rd_req while download_active=1; rd_req stays pending.
REQ-029 SHALL, in WRITE, pulse sd_wr with the popped address/data for 1 cycle, then go to WR_WAIT; WR_WAIT SHALL exit to IDLE on sd_busy=0.
REQ-030 SHALL, in READ, pulse sd_rd and rd_ack for 1 cycle with sd_addr=rd_addr, clear the timeout counter, then go to RD_WAIT.
REQ-031 SHALL, in RD_WAIT, latch sd_q on sd_q_valid, pulse rd_valid the next cycle, and return to IDLE.
REQ-032 SHALL, if RD_TIMEOUT cycles elapse in RD_WAIT without sd_q_valid, pulse rd_error, return to IDLE, and not assert rd_valid.
REQ-033 SHALL ignore sd_q_valid outside RD_WAIT.
REQ-034 SHALL drive load_idle=1 only when the FIFO is empty and the state is not WRITE/WR_WAIT.
REQ-035 SHALL provide a latency of 1 cycle from load_wr (IDLE, empty FIFO, sd_busy=0) to the grant, and sd_wr on the following cycle.

Reset
REQ-036 SHALL on reset go to IDLE and empty the FIFO, with sd_wr=sd_rd=rd_ack=rd_valid=rd_error=0, load_overflow=0, load_idle=1, rd_data=0, sd_addr=sd_din=0, and last_grant=read.
REQ-037 SHALL, on reset mid-operation, abandon the in-flight command and produce no later rd_valid/rd_error for it.

Structure
REQ-038 SHALL take the state enum and parameter defaults from shared package gnw_sdram_pkg.
REQ-039 SHALL implement the write buffer as sub-module sync_fifo (width ADDR_W+DATA_W, depth FIFO_DEPTH).

Verification
REQ-040 SHALL cover: 3 load_wr strobes (addrs 0x10-0x12, data 0xA000-0xA002) with sd_busy low 2 cycles per write -> 3 sd_wr pulses in order with matching sd_addr/sd_din, then load_idle=1.
REQ-041 SHALL cover: 6 load_wr back-to-back with sd_busy held high -> 4 accepted, load_overflow=1 from the 5th strobe.
REQ-042 SHALL cover: download_active=1 with rd_req high plus 2 writes -> no rd_ack; drop download_active -> rd_ack, and rd_valid with sd_q=0x5A5A.
REQ-043 SHALL cover: rd_req and FIFO non-empty together, download_active=0 -> grants alternate W,R,W,R.
REQ-044 SHALL cover: read with no sd_q_valid -> rd_error exactly 64 cycles after sd_rd, and no rd_valid.
REQ-045 SHALL cover: reset asserted in RD_WAIT, then sd_q_valid -> no rd_valid, all outputs at reset values.

Source files
------------

// File: rtl/gnw_sdram_pkg.sv
// Shared definitions for the SDRAM port arbiter: parameter defaults, FSM states and the grant flag.
package gnw_sdram_pkg;

  localparam int DEF_ADDR_W     = 25;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_RD_TIMEOUT = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_READ    = 3'd3,
    ST_RD_WAIT = 3'd4
  } arb_state_t;

  typedef enum logic {
    GRANT_WRITE = 1'b0,
    GRANT_READ  = 1'b1
  } grant_t;

  function automatic logic is_write_state(input arb_state_t s);
    return (s == ST_WRITE) || (s == ST_WR_WAIT);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fall-through head; a push and a pop complete in the same cycle they are strobed.
// The caller gates push: a push while full is only legal together with a pop.
module sync_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 4
) (
  input  logic                     clk_sys_131_072,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  always_ff @(posedge clk_sys_131_072) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_sys_131_072) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller between a FIFO-buffered ROM loader and a core read port; loader strobe to
// sd_wr takes 2 cycles when idle, and loader strobes arriving while the FIFO is full are dropped (sticky flag).
module sdram_port_arbiter
  import gnw_sdram_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int RD_TIMEOUT = DEF_RD_TIMEOUT
) (
  input  logic              clk_sys_131_072,
  input  logic              reset,
  input  logic              download_active,
  input  logic              load_wr,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_idle,
  output logic              load_overflow,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_error,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [DATA_W-1:0] sd_din,
  output logic              sd_wr,
  output logic              sd_rd,
  input  logic              sd_busy,
  input  logic [DATA_W-1:0] sd_q,
  input  logic              sd_q_valid
);

  localparam int CNT_W  = $clog2(RD_TIMEOUT) + 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  arb_state_t        state, state_nxt;
  grant_t            last_grant, last_grant_nxt;
  logic [CNT_W-1:0]  tmo_cnt, tmo_cnt_nxt;

  wr_entry_t         push_dat;
  wr_entry_t         pop_dat;
  logic              push_vld;
  logic              pop_vld;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCNT_W-1:0] fifo_count;
  logic [FCNT_W-1:0] fifo_count_nxt;

  logic              wr_pend;
  logic              rd_pend;

  logic              sd_wr_nxt, sd_rd_nxt, rd_ack_nxt, rd_valid_nxt, rd_error_nxt;
  logic              load_idle_nxt, load_overflow_nxt;
  logic [ADDR_W-1:0] sd_addr_nxt;
  logic [DATA_W-1:0] sd_din_nxt;
  logic [DATA_W-1:0] rd_data_nxt;

  assign push_dat = '{addr: load_addr, data: load_data};
  // A full FIFO still takes the strobe when the head leaves in the same cycle.
  assign push_vld = load_wr && (!fifo_full || pop_vld);
  assign wr_pend  = !fifo_empty;
  assign rd_pend  = rd_req && !download_active;

  sync_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk_sys_131_072 (clk_sys_131_072),
    .reset           (reset),
    .push            (push_vld),
    .din             (push_dat),
    .pop             (pop_vld),
    .dout            (pop_dat),
    .full            (fifo_full),
    .empty           (fifo_empty),
    .count           (fifo_count)
  );

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    tmo_cnt_nxt    = tmo_cnt;
    pop_vld        = 1'b0;
    sd_wr_nxt      = 1'b0;
    sd_rd_nxt      = 1'b0;
    rd_ack_nxt     = 1'b0;
    rd_valid_nxt   = 1'b0;
    rd_error_nxt   = 1'b0;
    sd_addr_nxt    = sd_addr;
    sd_din_nxt     = sd_din;
    rd_data_nxt    = rd_data;

    case (state)
      ST_IDLE: begin
        if (!sd_busy) begin
          if (wr_pend && (!rd_pend || last_grant == GRANT_READ)) begin
            pop_vld        = 1'b1;
            state_nxt      = ST_WRITE;
            last_grant_nxt = GRANT_WRITE;
            sd_wr_nxt      = 1'b1;
            sd_addr_nxt    = pop_dat.addr;
            sd_din_nxt     = pop_dat.data;
          end else if (rd_pend) begin
            state_nxt      = ST_READ;
            last_grant_nxt = GRANT_READ;
            sd_rd_nxt      = 1'b1;
            rd_ack_nxt     = 1'b1;
            sd_addr_nxt    = rd_addr;
          end
        end
      end
      ST_WRITE: state_nxt = ST_WR_WAIT;
      ST_WR_WAIT: begin
        if (!sd_busy) state_nxt = ST_IDLE;
      end
      ST_READ: begin
        state_nxt   = ST_RD_WAIT;
        tmo_cnt_nxt = '0;
      end
      ST_RD_WAIT: begin
        // Counter is 0 in the first wait cycle, so the error register lands RD_TIMEOUT cycles after sd_rd.
        if (sd_q_valid) begin
          rd_data_nxt  = sd_q;
          rd_valid_nxt = 1'b1;
          state_nxt    = ST_IDLE;
        end else if (tmo_cnt == CNT_W'(RD_TIMEOUT - 2)) begin
          rd_error_nxt = 1'b1;
          state_nxt    = ST_IDLE;
        end else begin
          tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    fifo_count_nxt    = fifo_count + FCNT_W'(push_vld) - FCNT_W'(pop_vld);
    load_idle_nxt     = (fifo_count_nxt == '0) && !is_write_state(state_nxt);
    load_overflow_nxt = load_overflow || (load_wr && !push_vld);
  end

  always_ff @(posedge clk_sys_131_072) begin
    if (reset) begin
      state         <= ST_IDLE;
      last_grant    <= GRANT_READ;
      tmo_cnt       <= '0;
      sd_wr         <= 1'b0;
      sd_rd         <= 1'b0;
      rd_ack        <= 1'b0;
      rd_valid      <= 1'b0;
      rd_error      <= 1'b0;
      sd_addr       <= '0;
      sd_din        <= '0;
      rd_data       <= '0;
      load_idle     <= 1'b1;
      load_overflow <= 1'b0;
    end else begin
      state         <= state_nxt;
      last_grant    <= last_grant_nxt;
      tmo_cnt       <= tmo_cnt_nxt;
      sd_wr         <= sd_wr_nxt;
      sd_rd         <= sd_rd_nxt;
      rd_ack        <= rd_ack_nxt;
      rd_valid      <= rd_valid_nxt;
      rd_error      <= rd_error_nxt;
      sd_addr       <= sd_addr_nxt;
      sd_din        <= sd_din_nxt;
      rd_data       <= rd_data_nxt;
      load_idle     <= load_idle_nxt;
      load_overflow <= load_overflow_nxt;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed and randomized bench: an SDRAM controller stub and a core-side requester respond to the DUT.
module tb_sdram_port_arbiter;

  localparam int AW    = 25;
  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int TMO   = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          download_active;
  logic          load_wr;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          load_idle;
  logic          load_overflow;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_error;
  logic [AW-1:0] sd_addr;
  logic [DW-1:0] sd_din;
  logic          sd_wr;
  logic          sd_rd;
  logic          sd_busy;
  logic [DW-1:0] sd_q;
  logic          sd_q_valid;

  always #5 clk = ~clk;

  sdram_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .RD_TIMEOUT(TMO)
  ) dut (
    .clk_sys_131_072 (clk),
    .reset           (reset),
    .download_active (download_active),
    .load_wr         (load_wr),
    .load_addr       (load_addr),
    .load_data       (load_data),
    .load_idle       (load_idle),
    .load_overflow   (load_overflow),
    .rd_req          (rd_req),
    .rd_addr         (rd_addr),
    .rd_ack          (rd_ack),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .rd_error        (rd_error),
    .sd_addr         (sd_addr),
    .sd_din          (sd_din),
    .sd_wr           (sd_wr),
    .sd_rd           (sd_rd),
    .sd_busy         (sd_busy),
    .sd_q            (sd_q),
    .sd_q_valid      (sd_q_valid)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation logs filled by the responder
  logic [AW-1:0] wr_addr_q[$];
  logic [DW-1:0] wr_din_q[$];
  int            wr_cyc_q[$];
  int            grant_q[$];        // 0 = write, 1 = read
  int            n_rd, n_ack, n_valid, n_err, rd_cyc, err_cyc;
  // Expectations
  logic [AW-1:0] exp_waddr_q[$];
  logic [DW-1:0] exp_wdin_q[$];
  logic [AW-1:0] rd_addr_exp_q[$];
  logic [DW-1:0] rd_dat_exp_q[$];
  // Stub / requester configuration
  int            reads_total, reads_issued, qv_total, qv_done;
  bit            force_busy, rand_busy, rd_respond, fixed_q_en;
  int            busy_len, lat_lo, lat_hi;
  logic [DW-1:0] fixed_q;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller stub, core read requester and output monitor
  initial begin : responder
    int busy_rem;
    int ret_rem;
    logic [DW-1:0] ret_dat;
    busy_rem = 0; ret_rem = 0; ret_dat = '0;
    sd_busy = 1'b0; sd_q = '0; sd_q_valid = 1'b0; rd_req = 1'b0; rd_addr = '0;
    forever begin
      @(negedge clk);
      sd_q_valid = 1'b0;
      if (reset) begin
        busy_rem = 0; ret_rem = 0;
        sd_busy = force_busy;
        rd_req = 1'b0;
        reads_issued = reads_total;
        rd_addr_exp_q.delete();
        rd_dat_exp_q.delete();
      end else begin
        if (sd_wr) begin
          wr_addr_q.push_back(sd_addr);
          wr_din_q.push_back(sd_din);
          wr_cyc_q.push_back(cyc);
          grant_q.push_back(0);
        end
        if (sd_rd) begin
          n_rd++;
          rd_cyc = cyc;
          grant_q.push_back(1);
          if (rd_addr_exp_q.size() > 0) check("sd_rd_addr", sd_addr, rd_addr_exp_q.pop_front());
          if (rd_respond) begin
            ret_rem = $urandom_range(lat_hi, lat_lo);
            ret_dat = fixed_q_en ? fixed_q : DW'($urandom);
          end
        end
        if (rd_valid) begin
          n_valid++;
          if (rd_dat_exp_q.size() > 0) check("rd_data", rd_data, rd_dat_exp_q.pop_front());
        end
        if (rd_error) begin
          n_err++;
          err_cyc = cyc;
        end
        if (sd_wr || sd_rd) busy_rem = rand_busy ? $urandom_range(3, 1) : busy_len;
        else if (busy_rem > 0) busy_rem--;
        sd_busy = force_busy || (busy_rem > 0);
        if (ret_rem > 0) begin
          ret_rem--;
          if (ret_rem == 0) begin
            sd_q_valid = 1'b1;
            sd_q = ret_dat;
            rd_dat_exp_q.push_back(ret_dat);
          end
        end
        if (qv_done < qv_total) begin
          qv_done++;
          sd_q_valid = 1'b1;
          sd_q = 16'hDEAD;
        end
        if (rd_ack) begin
          n_ack++;
          rd_req = 1'b0;
        end else if (!rd_req && reads_issued < reads_total) begin
          rd_addr = AW'($urandom);
          rd_addr_exp_q.push_back(rd_addr);
          rd_req = 1'b1;
          reads_issued++;
        end
      end
    end
  end

  task automatic clear_logs();
    wr_addr_q.delete(); wr_din_q.delete(); wr_cyc_q.delete(); grant_q.delete();
    exp_waddr_q.delete(); exp_wdin_q.delete();
    n_rd = 0; n_ack = 0; n_valid = 0; n_err = 0; rd_cyc = 0; err_cyc = 0;
  endtask

  task automatic do_reset();
    load_wr = 1'b0; download_active = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clear_logs();
  endtask

  task automatic strobe(input logic [AW-1:0] a, input logic [DW-1:0] d);
    load_addr = a; load_data = d; load_wr = 1'b1;
    @(negedge clk);
    load_wr = 1'b0;
  endtask

  task automatic strobe_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_waddr_q.push_back(a);
    exp_wdin_q.push_back(d);
    strobe(a, d);
  endtask

  task automatic wait_quiet(input string tag, input int budget);
    int quiet;
    quiet = 0;
    for (int i = 0; i < budget && quiet < 4; i++) begin
      @(negedge clk);
      if (load_idle && !sd_busy && !rd_req && reads_issued == reads_total &&
          (n_valid + n_err == n_ack)) quiet++;
      else quiet = 0;
    end
    check({tag, "_settled"}, quiet >= 4, 1);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_wr_count"}, wr_addr_q.size(), exp_waddr_q.size());
    for (int i = 0; i < exp_waddr_q.size() && i < wr_addr_q.size(); i++) begin
      check($sformatf("%s_wr%0d_addr", tag, i), wr_addr_q[i], exp_waddr_q[i]);
      check($sformatf("%s_wr%0d_din", tag, i), wr_din_q[i], exp_wdin_q[i]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sd_wr"}, sd_wr, 0);
    check({tag, "_sd_rd"}, sd_rd, 0);
    check({tag, "_rd_ack"}, rd_ack, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_error"}, rd_error, 0);
    check({tag, "_load_overflow"}, load_overflow, 0);
    check({tag, "_load_idle"}, load_idle, 1);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_sd_addr"}, sd_addr, 0);
    check({tag, "_sd_din"}, sd_din, 0);
  endtask

  initial begin : main
    int s_cyc;
    int model_occ;
    bit model_ovf;
    int exp_g[4];
    int t6_reads;
    int bound;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    reset = 1'b1; download_active = 1'b0; load_wr = 1'b0; load_addr = '0; load_data = '0;
    reads_total = 0; reads_issued = 0; qv_total = 0; qv_done = 0;
    force_busy = 1'b0; rand_busy = 1'b0; rd_respond = 1'b1; fixed_q_en = 1'b0; fixed_q = '0;
    busy_len = 2; lat_lo = 3; lat_hi = 3;
    clear_logs();
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Three loader writes, first one also checks strobe-to-sd_wr latency
    s_cyc = cyc;
    for (int i = 0; i < 3; i++) strobe_exp(AW'(32'h10 + i), DW'(32'hA000 + i));
    wait_quiet("seq3", 200);
    check_writes("seq3");
    if (wr_cyc_q.size() > 0) check("seq3_latency", wr_cyc_q[0] - s_cyc, 2);
    check("seq3_load_idle", load_idle, 1);

    // Six back-to-back strobes against a stalled controller
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    model_occ = 0; model_ovf = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a = AW'($urandom); d = DW'($urandom);
      if (model_occ < DEPTH) begin
        model_occ++;
        exp_waddr_q.push_back(a);
        exp_wdin_q.push_back(d);
      end else begin
        model_ovf = 1'b1;
      end
      strobe(a, d);
      check($sformatf("ovf_after_%0d", i + 1), load_overflow, model_ovf);
    end
    check("ovf_load_idle_busy", load_idle, 0);
    force_busy = 1'b0;
    wait_quiet("ovf", 300);
    check_writes("ovf");
    check("ovf_sticky", load_overflow, 1);
    do_reset();
    check("ovf_cleared_by_reset", load_overflow, 0);

    // Reads blocked during download while writes proceed
    download_active = 1'b1;
    fixed_q_en = 1'b1; fixed_q = 16'h5A5A;
    reads_total++;
    strobe_exp(AW'($urandom), DW'($urandom));
    repeat (10) @(negedge clk);
    strobe_exp(AW'($urandom), DW'($urandom));
    repeat (30) @(negedge clk);
    check("dl_no_ack", n_ack, 0);
    check("dl_no_sd_rd", n_rd, 0);
    check("dl_rd_req_pending", rd_req, 1);
    check_writes("dl");
    download_active = 1'b0;
    wait_quiet("dl_release", 200);
    check("dl_ack", n_ack, 1);
    check("dl_valid", n_valid, 1);
    check("dl_rd_data_5a5a", rd_data, 16'h5A5A);
    fixed_q_en = 1'b0;

    // Both requesters pending: grants alternate starting with the write
    do_reset();
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    strobe_exp(AW'($urandom), DW'($urandom));
    strobe_exp(AW'($urandom), DW'($urandom));
    reads_total += 2;
    repeat (3) @(negedge clk);
    force_busy = 1'b0;
    wait_quiet("alt", 300);
    exp_g = '{0, 1, 0, 1};
    check("alt_grant_count", grant_q.size(), 4);
    for (int i = 0; i < 4 && i < grant_q.size(); i++)
      check($sformatf("alt_grant%0d", i), grant_q[i], exp_g[i]);
    check_writes("alt");
    check("alt_valid", n_valid, 2);

    // Read timeout, then a stray sd_q_valid while idle
    do_reset();
    rd_respond = 1'b0;
    reads_total++;
    bound = 0;
    while (n_err == 0 && bound < 200) begin
      @(negedge clk);
      bound++;
    end
    check("tmo_seen", n_err, 1);
    check("tmo_distance", err_cyc - rd_cyc, TMO);
    check("tmo_no_valid", n_valid, 0);
    qv_total++;
    repeat (6) @(negedge clk);
    check("stray_qv_no_valid", n_valid, 0);
    check("stray_qv_no_error", n_err, 1);
    rd_respond = 1'b1;

    // Randomized mix of loader writes and core reads
    do_reset();
    rand_busy = 1'b1; lat_lo = 1; lat_hi = 12;
    t6_reads = 0;
    for (int it = 0; it < 14; it++) begin
      if ($urandom_range(1, 0) == 1) strobe_exp(AW'($urandom), DW'($urandom));
      if ($urandom_range(2, 0) == 0) begin
        reads_total++;
        t6_reads++;
      end
      repeat ($urandom_range(30, 20)) @(negedge clk);
    end
    wait_quiet("rand", 2000);
    check_writes("rand");
    check("rand_valid", n_valid, t6_reads);
    check("rand_no_error", n_err, 0);
    check("rand_no_overflow", load_overflow, 0);
    rand_busy = 1'b0;

    // Reset while waiting for read data abandons the read
    do_reset();
    rd_respond = 1'b0;
    reads_total++;
    bound = 0;
    while (n_rd == 0 && bound < 50) begin
      @(negedge clk);
      bound++;
    end
    check("rstmid_read_started", n_rd, 1);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    qv_total++;
    repeat (80) @(negedge clk);
    check("rstmid_no_valid", n_valid, 0);
    check("rstmid_no_error", n_err, 0);
    check_reset_outputs("rstmid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
